// File: rtl/sap_io_defs.sv
// -----------------------------------------------------------------------------
// sap_io_defs
//   Shared definitions for the SAP board I/O ports: data width, the default
//   debounce length and the per-bit debounce state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package sap_io_defs;

  localparam int SAP_PORT_W          = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } deb_state_t;

endpackage : sap_io_defs

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//   One button bit: 2-FF synchronizer on the raw active-low pin, then a
//   STABLE/CHANGING debounce FSM that accepts a new level only after
//   DEBOUNCE_CYCLES consecutive samples that differ from the current level.
// Ports
//   clk    in   CPU clock, rising edge
//   rst    in   asynchronous reset, active-low
//   pin_n  in   raw button pin, active-low, asynchronous to clk
//   level  out  debounced state, active-high (1 = pressed), registered
//   press  out  one-cycle pulse on the cycle level rises, registered
// -----------------------------------------------------------------------------
module input_debouncer
  import sap_io_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             sample_s;
  deb_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-flop synchronizer; resets to 1 so a released button reads as idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= pin_n;
      sync2_r <= sync1_r;
    end
  end

  assign sample_s = ~sync2_r;

  // Debounce FSM with its counter, accepted level and press pulse.
  // The counter tracks how many consecutive differing samples have been seen,
  // so the level flips on the DEBOUNCE_CYCLES-th one and cnt never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_STABLE;
      cnt_r   <= CNT_ZERO;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state_r)
        ST_STABLE: begin
          if (sample_s != level) begin
            cnt_r   <= CNT_ONE;
            state_r <= ST_CHANGING;
          end else begin
            cnt_r   <= CNT_ZERO;
            state_r <= ST_STABLE;
          end
        end
        ST_CHANGING: begin
          if (sample_s == level) begin
            // Bounce back to the accepted level: abandon the change.
            cnt_r   <= CNT_ZERO;
            state_r <= ST_STABLE;
          end else if (cnt_r == CNT_LAST) begin
            level   <= sample_s;
            press   <= sample_s;  // only 0->1 transitions are events
            cnt_r   <= CNT_ZERO;
            state_r <= ST_STABLE;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= ST_CHANGING;
          end
        end
        default: begin
          cnt_r   <= CNT_ZERO;
          state_r <= ST_STABLE;
        end
      endcase
    end
  end

endmodule : input_debouncer

// File: rtl/sap_input_port.sv
// -----------------------------------------------------------------------------
// sap_input_port
//   CPU-facing input port for four active-low board buttons. Each bit is
//   synchronized and debounced; rising debounced levels set sticky pending
//   bits which the CPU consumes with a read-and-clear strobe.
// Ports
//   clk       in   CPU clock (divided clock feeding the cpu), rising edge
//   rst       in   asynchronous reset, active-low
//   pins_n    in   [WIDTH] raw button pins, active-low, asynchronous
//   rd_en     in   one-cycle read strobe; snapshots and clears pending
//   level     out  [WIDTH] debounced button state, active-high
//   pending   out  [WIDTH] sticky press-event flags
//   any_pend  out  OR of pending (poll / interrupt request)
//   rd_data   out  [WIDTH] pending snapshot taken by the last rd_en
// -----------------------------------------------------------------------------
module sap_input_port
  import sap_io_defs::*;
#(
  parameter int WIDTH           = SAP_PORT_W,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins_n,
  input  logic             rd_en,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pending,
  output logic             any_pend,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] press_s;
  logic [WIDTH-1:0] pending_r;
  logic [WIDTH-1:0] rd_data_r;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    input_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .pin_n (pins_n[g]),
      .level (level[g]),
      .press (press_s[g])
    );
  end

  // Pending flags and read snapshot. A press arriving with rd_en wins, so an
  // event is never lost; rd_data returns the pre-clear pending value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r <= {WIDTH{1'b0}};
      rd_data_r <= {WIDTH{1'b0}};
    end else begin
      pending_r <= press_s | (pending_r & ~{WIDTH{rd_en}});
      if (rd_en) begin
        rd_data_r <= pending_r;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign pending  = pending_r;
  assign rd_data  = rd_data_r;
  assign any_pend = |pending_r;

endmodule : sap_input_port

// File: tb/tb_sap_input_port.sv
// -----------------------------------------------------------------------------
// tb_sap_input_port
//   Self-checking bench for sap_input_port (WIDTH=4, DEBOUNCE_CYCLES=4).
//   Directed scenarios followed by random pin/read activity, all compared
//   against a cycle-level reference model of the port's behaviour.
// -----------------------------------------------------------------------------
module tb_sap_input_port;

  localparam int W   = 4;
  localparam int DEB = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] pins_n;
  logic         rd_en;
  logic [W-1:0] level;
  logic [W-1:0] pending;
  logic         any_pend;
  logic [W-1:0] rd_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: two-cycle pin delay, accepted level, run length of
  // differing samples, press pulse, pending flags and read snapshot.
  logic [W-1:0] m_d1, m_d2, m_level, m_press, m_pending, m_rd_data;
  int           m_run [W];

  sap_input_port #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pins_n   (pins_n),
    .rd_en    (rd_en),
    .level    (level),
    .pending  (pending),
    .any_pend (any_pend),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_d1      = 4'b1111;
    m_d2      = 4'b1111;
    m_level   = 4'b0000;
    m_press   = 4'b0000;
    m_pending = 4'b0000;
    m_rd_data = 4'b0000;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    logic [W-1:0] p, s, nl, np;
    logic         r;
    p = pins_n;
    r = rd_en;
    @(posedge clk);
    s  = ~m_d2;
    nl = m_level;
    np = 4'b0000;
    for (int i = 0; i < W; i++) begin
      if (s[i] !== m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          nl[i]    = s[i];
          np[i]    = s[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (r) m_rd_data = m_pending;
    m_pending = m_press | (m_pending & ~{W{r}});
    m_press   = np;
    m_level   = nl;
    m_d2      = m_d1;
    m_d1      = p;
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"},    level,    m_level);
    chk({tag, ".pending"},  pending,  m_pending);
    chk({tag, ".any_pend"}, {3'b000, any_pend}, {3'b000, |m_pending});
    chk({tag, ".rd_data"},  rd_data,  m_rd_data);
  endtask

  task automatic tick_chk(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      check_all(tag);
    end
  endtask

  task automatic read_pulse(input string tag);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst    = 1'b0;
    pins_n = 4'b1111;
    rd_en  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.level",   level,   4'b0000);
    chk("rst.pending", pending, 4'b0000);
    chk("rst.rd_data", rd_data, 4'b0000);
    chk("rst.any",     {3'b000, any_pend}, 4'b0000);
    rst = 1'b1;

    // Idle for 50 cycles: nothing changes.
    tick_chk(50, "idle");
    chk("idle.level",   level,   4'b0000);
    chk("idle.pending", pending, 4'b0000);
    chk("idle.rd_data", rd_data, 4'b0000);

    // Bit 0 pressed and held: level after exactly 6 cycles.
    pins_n = 4'b1110;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_all("press0");
      if (k == 5) chk("press0.lat5", level, 4'b0000);
      if (k == 6) chk("press0.lat6", level, 4'b0001);
    end
    tick();
    check_all("press0.pend");
    chk("press0.pending", pending, 4'b0001);
    chk("press0.any",     {3'b000, any_pend}, 4'b0001);
    read_pulse("rd0");
    chk("rd0.rd_data", rd_data, 4'b0001);
    chk("rd0.pending", pending, 4'b0000);

    // Bit 2 bouncing with 2-cycle half periods never gets accepted.
    for (int k = 0; k < 10; k++) begin
      pins_n[2] = ~pins_n[2];
      tick_chk(2, "bounce");
    end
    tick_chk(10, "bounce.hold");
    chk("bounce.level2",  {3'b000, level[2]}, 4'b0000);
    chk("bounce.pending", pending, 4'b0000);

    // Bits 1 and 3 pressed, then read-and-clear twice.
    pins_n = 4'b0100;
    tick_chk(8, "press13");
    chk("press13.pending", pending, 4'b1010);
    read_pulse("rd13");
    chk("rd13.rd_data", rd_data, 4'b1010);
    chk("rd13.pending", pending, 4'b0000);
    chk("rd13.any",     {3'b000, any_pend}, 4'b0000);
    read_pulse("rd13b");
    chk("rd13b.rd_data", rd_data, 4'b0000);

    // Read strobe coincides with the bit-0 press pulse: the press survives.
    pins_n = 4'b0101;
    tick_chk(10, "rel0");
    pins_n = 4'b0100;
    tick_chk(6, "repress0");
    chk("repress0.level", level, 4'b1011);
    read_pulse("rdpress");
    chk("rdpress.pending", pending, 4'b0001);
    chk("rdpress.rd_data", rd_data, 4'b0000);

    // Build non-zero state, then reset in the middle of a bit-0 debounce.
    pins_n = 4'b1111;
    tick_chk(10, "relall");
    read_pulse("rdall");
    pins_n = 4'b0111;
    tick_chk(8, "press3");
    pins_n = 4'b1111;
    tick_chk(8, "rel3");
    pins_n = 4'b1110;
    tick_chk(5, "midrst.pre");
    rst = 1'b0;
    #1;
    model_reset();
    chk("midrst.level",   level,   4'b0000);
    chk("midrst.pending", pending, 4'b0000);
    chk("midrst.rd_data", rd_data, 4'b0000);
    chk("midrst.any",     {3'b000, any_pend}, 4'b0000);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_all("midrst.post");
      if (k == 5) chk("midrst.lat5", level, 4'b0000);
      if (k == 6) chk("midrst.lat6", level, 4'b0001);
    end
    tick_chk(11, "midrst.hold");
    chk("midrst.pending1", pending, 4'b0001);
    read_pulse("midrst.rd");
    chk("midrst.rd_data", rd_data, 4'b0001);
    read_pulse("midrst.rd2");
    chk("midrst.rd_data2", rd_data, 4'b0000);

    // Random pin activity and read strobes against the model.
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(5, 0) == 0) pins_n[b] = ~pins_n[b];
      end
      rd_en = ($urandom_range(3, 0) == 0);
      tick();
      check_all("rand");
    end
    rd_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_sap_input_port
